// File: rtl/speed_round_scorer.sv
// N-player speed-round press counter: synchronises buttons, counts presses while the round is open,
// then scans the counters one per cycle for winner/tie/max. Optional false-start detection: FALSE_START_EN.
module speed_round_scorer #(
    parameter int NUM_PLAYERS = 2,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PLAYERS-1:0] push,
    input  logic                   speed_round,
    input  logic                   speed_exit,
    input  logic [IDX_W-1:0]       rd_sel,
    output logic [CNT_W-1:0]       rd_count,
    output logic                   busy,
    output logic                   result_valid,
    output logic [IDX_W-1:0]       winner,
    output logic                   tie,
    output logic [CNT_W-1:0]       max_count
`ifdef FALSE_START_EN
    ,
    output logic [NUM_PLAYERS-1:0] dq
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] SCAN  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAYERS - 1);

    logic [1:0]             state;
    logic [NUM_PLAYERS-1:0] sync1, sync2, sync2_prev, pulse;
    logic [CNT_W-1:0]       cnt [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] dq_vec;

    logic [IDX_W-1:0] scan_idx, best_idx, nxt_idx;
    logic [CNT_W-1:0] best_cnt, nxt_cnt, cur_cnt;
    logic             best_tie, nxt_tie, have_best, nxt_have, cur_dq;

    // Two flops for metastability, a third to find the rising edge of the clean level.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= '0;
            sync2      <= '0;
            sync2_prev <= '0;
        end else begin
            sync1      <= push;
            sync2      <= sync1;
            sync2_prev <= sync2;
        end
    end

    assign pulse = sync2 & ~sync2_prev;

`ifdef FALSE_START_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq_vec <= '0;
        end else if (speed_exit) begin
            dq_vec <= '0;
        end else if (state == IDLE) begin
            dq_vec <= dq_vec | pulse;
        end
    end

    assign dq = dq_vec;
`else
    assign dq_vec = '0;
`endif

    // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PLAYERS; i++) cnt[i] <= '0;
        end else if (speed_exit) begin
            for (int i = 0; i < NUM_PLAYERS; i++) cnt[i] <= '0;
        end else if (state == COUNT) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                if (pulse[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    // Loop-based selection keeps out-of-range indices (non power-of-two player counts) reading zero.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cur_cnt  = '0;
        cur_dq   = 1'b0;
        rd_count = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_cnt = cnt[i];
                cur_dq  = dq_vec[i];
            end
            if (rd_sel == IDX_W'(i)) rd_count = cnt[i];
        end
    end

    always_comb begin
        nxt_cnt  = best_cnt;
        nxt_idx  = best_idx;
        nxt_tie  = best_tie;
        nxt_have = have_best;
        if (!cur_dq) begin
            if (!have_best || cur_cnt > best_cnt) begin
                nxt_cnt  = cur_cnt;
                nxt_idx  = scan_idx;
                nxt_tie  = 1'b0;
                nxt_have = 1'b1;
            end else if (cur_cnt == best_cnt) begin
                nxt_tie = 1'b1;
            end
        end
        // Nobody eligible: report an all-way tie at zero.
        if (scan_idx == LAST_IDX && !nxt_have) begin
            nxt_cnt = '0;
            nxt_idx = '0;
            nxt_tie = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            scan_idx  <= '0;
            best_idx  <= '0;
            best_cnt  <= '0;
            best_tie  <= 1'b0;
            have_best <= 1'b0;
        end else if (speed_exit) begin
            state     <= IDLE;
            scan_idx  <= '0;
            best_idx  <= '0;
            best_cnt  <= '0;
            best_tie  <= 1'b0;
            have_best <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (speed_round) state <= COUNT;
                end
                COUNT: begin
                    if (!speed_round) begin
                        state     <= SCAN;
                        scan_idx  <= '0;
                        best_idx  <= '0;
                        best_cnt  <= '0;
                        best_tie  <= 1'b0;
                        have_best <= 1'b0;
                    end
                end
                SCAN: begin
                    best_cnt  <= nxt_cnt;
                    best_idx  <= nxt_idx;
                    best_tie  <= nxt_tie;
                    have_best <= nxt_have;
                    scan_idx  <= scan_idx + IDX_W'(1);
                    if (scan_idx == LAST_IDX) state <= DONE;
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end

    assign result_valid = (state == DONE);
    assign busy         = (state == COUNT) || (state == SCAN);
    assign winner       = result_valid ? best_idx : '0;
    assign tie          = result_valid ? best_tie : 1'b0;
    assign max_count    = result_valid ? best_cnt : '0;

endmodule

// File: tb/tb_speed_round_scorer.sv
// Directed bench for speed_round_scorer: a 4-player/8-bit instance and a 2-player/3-bit instance
// for saturation and mid-round reset. Build with FALSE_START_EN to exercise the dq path.
module tb_speed_round_scorer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] push4  = '0;
    logic       round4 = 1'b0;
    logic       exit4  = 1'b0;
    logic [1:0] sel4   = '0;
    logic [7:0] rd_count4, max4;
    logic       busy4, valid4, tie4;
    logic [1:0] winner4;

    logic [1:0] push2  = '0;
    logic       round2 = 1'b0;
    logic       exit2  = 1'b0;
    logic       sel2   = 1'b0;
    logic [2:0] rd_count2, max2;
    logic       busy2, valid2, tie2;
    logic       winner2;

`ifdef FALSE_START_EN
    logic [3:0] dq4;
    logic [1:0] dq2;
`endif

    int checks = 0;
    int errors = 0;

    speed_round_scorer #(.NUM_PLAYERS(4), .CNT_W(8), .IDX_W(2)) dut4 (
        .clk(clk), .rst(rst), .push(push4), .speed_round(round4), .speed_exit(exit4),
        .rd_sel(sel4), .rd_count(rd_count4), .busy(busy4), .result_valid(valid4),
        .winner(winner4), .tie(tie4), .max_count(max4)
`ifdef FALSE_START_EN
        , .dq(dq4)
`endif
    );

    speed_round_scorer #(.NUM_PLAYERS(2), .CNT_W(3), .IDX_W(1)) dut2 (
        .clk(clk), .rst(rst), .push(push2), .speed_round(round2), .speed_exit(exit2),
        .rd_sel(sel2), .rd_count(rd_count2), .busy(busy2), .result_valid(valid2),
        .winner(winner2), .tie(tie2), .max_count(max2)
`ifdef FALSE_START_EN
        , .dq(dq2)
`endif
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press4(input int c0, input int c1, input int c2, input int c3);
        int m;
        m = c0;
        if (c1 > m) m = c1;
        if (c2 > m) m = c2;
        if (c3 > m) m = c3;
        for (int k = 0; k < m; k++) begin
            push4 = {c3 > k, c2 > k, c1 > k, c0 > k};
            step(2);
            push4 = '0;
            step(2);
        end
        step(4);
    endtask

    task automatic press2(input int c0, input int c1);
        int m;
        m = (c0 > c1) ? c0 : c1;
        for (int k = 0; k < m; k++) begin
            push2 = {c1 > k, c0 > k};
            step(2);
            push2 = '0;
            step(2);
        end
        step(4);
    endtask

    task automatic wait_done4();
        int n = 0;
        while (valid4 !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (valid4 !== 1'b1) begin
            errors++;
            $display("FAIL done4_timeout got %0b want 1", valid4);
        end
    endtask

    task automatic wait_done2();
        int n = 0;
        while (valid2 !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        checks++;
        if (valid2 !== 1'b1) begin
            errors++;
            $display("FAIL done2_timeout got %0b want 1", valid2);
        end
    endtask

    task automatic exit_round4();
        exit4 = 1'b1;
        step(1);
        exit4 = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        checks++;
        if ({busy4, valid4, winner4, tie4, max4, rd_count4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs4 got %0h want 0", {busy4, valid4, winner4, tie4, max4, rd_count4});
        end
        checks++;
        if ({busy2, valid2, winner2, tie2, max2, rd_count2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs2 got %0h want 0", {busy2, valid2, winner2, tie2, max2, rd_count2});
        end
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_basic_round();
        logic [7:0] exp_cnt [4];
        exp_cnt = '{8'd3, 8'd7, 8'd2, 8'd5};
        round4 = 1'b1;
        step(1);
        checks++;
        if (busy4 !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_count got %0b want 1", busy4);
        end
        press4(3, 7, 2, 5);
        for (int i = 0; i < 4; i++) begin
            sel4 = 2'(i);
            #1;
            checks++;
            if (rd_count4 !== exp_cnt[i]) begin
                errors++;
                $display("FAIL basic_rd_count%0d got %0d want %0d", i, rd_count4, exp_cnt[i]);
            end
        end
        round4 = 1'b0;
        step(4);
        checks++;
        if (busy4 !== 1'b1 || valid4 !== 1'b0) begin
            errors++;
            $display("FAIL basic_scan_len got busy=%0b valid=%0b want busy=1 valid=0", busy4, valid4);
        end
        step(1);
        checks++;
        if (valid4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got valid=%0b busy=%0b want valid=1 busy=0", valid4, busy4);
        end
        checks++;
        if (winner4 !== 2'd1 || tie4 !== 1'b0 || max4 !== 8'd7) begin
            errors++;
            $display("FAIL basic_result got w=%0d t=%0b m=%0d want w=1 t=0 m=7", winner4, tie4, max4);
        end
        exit_round4();
        checks++;
        if ({busy4, valid4, winner4, tie4, max4} !== '0) begin
            errors++;
            $display("FAIL exit_done_outputs got %0h want 0", {busy4, valid4, winner4, tie4, max4});
        end
        for (int i = 0; i < 4; i++) begin
            sel4 = 2'(i);
            #1;
            checks++;
            if (rd_count4 !== 8'd0) begin
                errors++;
                $display("FAIL exit_done_rd_count%0d got %0d want 0", i, rd_count4);
            end
        end
    endtask

    task automatic test_tie();
        round4 = 1'b1;
        step(1);
        press4(2, 6, 2, 6);
        round4 = 1'b0;
        wait_done4();
        checks++;
        if (winner4 !== 2'd1 || tie4 !== 1'b1 || max4 !== 8'd6) begin
            errors++;
            $display("FAIL tie_result got w=%0d t=%0b m=%0d want w=1 t=1 m=6", winner4, tie4, max4);
        end
        exit_round4();
    endtask

    task automatic test_zero_round();
        round4 = 1'b1;
        step(4);
        round4 = 1'b0;
        wait_done4();
        checks++;
        if (winner4 !== 2'd0 || tie4 !== 1'b1 || max4 !== 8'd0) begin
            errors++;
            $display("FAIL zero_result got w=%0d t=%0b m=%0d want w=0 t=1 m=0", winner4, tie4, max4);
        end
        exit_round4();
    endtask

    task automatic test_exit_mid_scan();
        round4 = 1'b1;
        step(1);
        press4(1, 2, 3, 4);
        round4 = 1'b0;
        step(3);
        exit_round4();
        checks++;
        if ({busy4, valid4, winner4, tie4, max4} !== '0) begin
            errors++;
            $display("FAIL exit_scan_outputs got %0h want 0", {busy4, valid4, winner4, tie4, max4});
        end
        for (int i = 0; i < 4; i++) begin
            sel4 = 2'(i);
            #1;
            checks++;
            if (rd_count4 !== 8'd0) begin
                errors++;
                $display("FAIL exit_scan_rd_count%0d got %0d want 0", i, rd_count4);
            end
        end
        step(6);
        checks++;
        if (valid4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL exit_scan_stays_idle got valid=%0b busy=%0b want 0 0", valid4, busy4);
        end
    endtask

    task automatic test_hold_done();
        round4 = 1'b1;
        step(1);
        press4(0, 0, 1, 0);
        round4 = 1'b0;
        wait_done4();
        round4 = 1'b1;
        press4(5, 0, 0, 0);
        sel4 = 2'd0;
        #1;
        checks++;
        if (valid4 !== 1'b1 || winner4 !== 2'd2 || tie4 !== 1'b0 || max4 !== 8'd1) begin
            errors++;
            $display("FAIL hold_done_result got v=%0b w=%0d t=%0b m=%0d want v=1 w=2 t=0 m=1",
                     valid4, winner4, tie4, max4);
        end
        checks++;
        if (rd_count4 !== 8'd0) begin
            errors++;
            $display("FAIL hold_done_no_count got %0d want 0", rd_count4);
        end
        exit_round4();
        checks++;
        if (busy4 !== 1'b0 || valid4 !== 1'b0) begin
            errors++;
            $display("FAIL exit_beats_round got busy=%0b valid=%0b want 0 0", busy4, valid4);
        end
        step(1);
        checks++;
        if (busy4 !== 1'b1) begin
            errors++;
            $display("FAIL reenter_count got busy=%0b want 1", busy4);
        end
        round4 = 1'b0;
        wait_done4();
        exit_round4();
    endtask

    task automatic test_saturate();
        round2 = 1'b1;
        step(1);
        press2(10, 0);
        sel2 = 1'b0;
        #1;
        checks++;
        if (rd_count2 !== 3'd7) begin
            errors++;
            $display("FAIL saturate_count got %0d want 7", rd_count2);
        end
        push2 = 2'b10;
        step(20);
        push2 = 2'b00;
        step(4);
        sel2 = 1'b1;
        #1;
        checks++;
        if (rd_count2 !== 3'd1) begin
            errors++;
            $display("FAIL held_button got %0d want 1", rd_count2);
        end
        round2 = 1'b0;
        wait_done2();
        checks++;
        if (winner2 !== 1'b0 || tie2 !== 1'b0 || max2 !== 3'd7) begin
            errors++;
            $display("FAIL saturate_result got w=%0d t=%0b m=%0d want w=0 t=0 m=7", winner2, tie2, max2);
        end
        exit2 = 1'b1;
        step(1);
        exit2 = 1'b0;
    endtask

    task automatic test_reset_mid_count();
        round2 = 1'b1;
        step(1);
        press2(4, 4);
        sel2 = 1'b1;
        #1;
        checks++;
        if (rd_count2 !== 3'd4 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got cnt=%0d busy=%0b want 4 1", rd_count2, busy2);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({busy2, valid2, winner2, tie2, max2, rd_count2} !== '0) begin
            errors++;
            $display("FAIL async_reset got %0h want 0", {busy2, valid2, winner2, tie2, max2, rd_count2});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1);
        checks++;
        if (busy2 !== 1'b1 || rd_count2 !== 3'd0) begin
            errors++;
            $display("FAIL after_reset_round got busy=%0b cnt=%0d want 1 0", busy2, rd_count2);
        end
        press2(1, 0);
        round2 = 1'b0;
        wait_done2();
        checks++;
        if (winner2 !== 1'b0 || tie2 !== 1'b0 || max2 !== 3'd1) begin
            errors++;
            $display("FAIL after_reset_result got w=%0d t=%0b m=%0d want w=0 t=0 m=1", winner2, tie2, max2);
        end
        exit2 = 1'b1;
        step(1);
        exit2 = 1'b0;
    endtask

`ifdef FALSE_START_EN
    task automatic test_false_start();
        press4(0, 0, 1, 0);
        checks++;
        if (dq4 !== 4'b0100) begin
            errors++;
            $display("FAIL dq_set got %b want 0100", dq4);
        end
        round4 = 1'b1;
        step(1);
        press4(4, 0, 9, 0);
        round4 = 1'b0;
        wait_done4();
        checks++;
        if (winner4 !== 2'd0 || tie4 !== 1'b0 || max4 !== 8'd4 || dq4 !== 4'b0100) begin
            errors++;
            $display("FAIL false_start_result got w=%0d t=%0b m=%0d dq=%b want w=0 t=0 m=4 dq=0100",
                     winner4, tie4, max4, dq4);
        end
        exit_round4();
        checks++;
        if (dq4 !== 4'b0000) begin
            errors++;
            $display("FAIL dq_clear got %b want 0000", dq4);
        end
    endtask
`else
    task automatic test_idle_ignored();
        press4(0, 0, 3, 0);
        round4 = 1'b1;
        step(1);
        sel4 = 2'd2;
        #1;
        checks++;
        if (rd_count4 !== 8'd0) begin
            errors++;
            $display("FAIL idle_press_counted got %0d want 0", rd_count4);
        end
        round4 = 1'b0;
        wait_done4();
        checks++;
        if (tie4 !== 1'b1 || max4 !== 8'd0) begin
            errors++;
            $display("FAIL idle_round_result got t=%0b m=%0d want t=1 m=0", tie4, max4);
        end
        exit_round4();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_round();
        test_tie();
        test_zero_round();
        test_exit_mid_scan();
        test_hold_done();
        test_saturate();
        test_reset_mid_count();
`ifdef FALSE_START_EN
        test_false_start();
`else
        test_idle_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
